// File: rtl/raid0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : raid0_pkg
// Description : Shared types and helpers for the RAID0 stripe writer.
//               Fill-side and drain-side state encodings, plus constant
//               functions for words-per-stripe and ceiling log2.
// Revision    : 1.0 - initial release
// ============================================================================
package raid0_pkg;

    typedef enum logic [0:0] {
        F_IDLE = 1'b0,
        F_FILL = 1'b1
    } fill_state_e;

    typedef enum logic [0:0] {
        D_IDLE  = 1'b0,
        D_WRITE = 1'b1
    } drain_state_e;

    // Host words that make up one full stripe across all lanes.
    function automatic int calc_wps(input int ndevice, input int dwidth_device,
                                    input int dwidth_host);
        return (ndevice * dwidth_device) / dwidth_host;
    endfunction

    // Ceiling log2; exact for the power-of-two values used here.
    function automatic int calc_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : raid0_pkg
`default_nettype wire

// File: rtl/raid0_stripe_buf.sv
`default_nettype none
// ============================================================================
// Module      : raid0_stripe_buf
// Description : DEPTH-entry FIFO of committed {addr, stripe} entries.
//               Head entry is presented combinationally on head_data.
// Ports       : clk, reset_n (async, active-low)
//               push/push_data  - write an entry (never while full)
//               pop             - retire the head entry (never while empty)
//               head_data       - oldest entry
//               occupancy, full, empty - fill level status
// Revision    : 1.0 - initial release
// ============================================================================
module raid0_stripe_buf
    import raid0_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head_data,
    output logic [calc_log2(DEPTH):0]   occupancy,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = calc_log2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        occ_d    = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign occupancy = occ_q;
    assign full      = (occ_q == OCC_W'(DEPTH));
    assign empty     = (occ_q == '0);

endmodule : raid0_stripe_buf
`default_nettype wire

// File: rtl/raid0_stripe_writer.sv
`default_nettype none
// ============================================================================
// Module      : raid0_stripe_writer
// Description : RAID0 write path. Packs host words into stripes of
//               NDEVICE*DWIDTHDEVICE bits, buffers up to NSTRIPE committed
//               stripes and issues independent one-cycle write strobes per
//               device so a busy device only stalls its own lane.
// Ports       : clk, reset_n (async, active-low), enable
//               host_valid/host_ready/host_data/host_addr/host_last - host side
//               device_data/device_addr/device_write/device_busy - device side
//               busy            - stripe partially filled, buffered or draining
//               stripes_written - popped-stripe counter (RAID0_STRIPE_STAT_EN)
// Config      : define RAID0_STRIPE_STAT_EN to add the stripes_written port.
// Revision    : 1.0 - initial release
// ============================================================================
module raid0_stripe_writer
    import raid0_pkg::*;
#(
    parameter int NDEVICE       = 8,
    parameter int DWIDTHHOST    = 32,
    parameter int ADDRWIDTHHOST = 32,
    parameter int DWIDTHDEVICE  = 8,
    parameter int NSTRIPE       = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic                              host_valid,
    output logic                              host_ready,
    input  logic [DWIDTHHOST-1:0]             host_data,
    input  logic [ADDRWIDTHHOST-1:0]          host_addr,
    input  logic                              host_last,
    output logic [NDEVICE*DWIDTHDEVICE-1:0]   device_data,
    output logic [ADDRWIDTHHOST-1:0]          device_addr,
    output logic [NDEVICE-1:0]                device_write,
    input  logic [NDEVICE-1:0]                device_busy,
    output logic                              busy
`ifdef RAID0_STRIPE_STAT_EN
    ,
    output logic [31:0]                       stripes_written
`endif
);

    localparam int SW       = NDEVICE * DWIDTHDEVICE;
    localparam int WPS      = calc_wps(NDEVICE, DWIDTHDEVICE, DWIDTHHOST);
    localparam int WPS_LOG2 = calc_log2(WPS);
    localparam int CNT_W    = (WPS_LOG2 > 0) ? WPS_LOG2 : 1;
    localparam int ENTRY_W  = ADDRWIDTHHOST + SW;
    localparam int OCC_W    = calc_log2(NSTRIPE) + 1;

    // ---------------------------------------------------------------- fill
    fill_state_e              fill_state_q, fill_state_d;
    logic [CNT_W-1:0]         fill_cnt_q, fill_cnt_d;
    logic [SW-1:0]            stripe_q, stripe_d, w_stripe_merged;
    logic [ADDRWIDTHHOST-1:0] addr_q, addr_d, w_stripe_addr;
    logic                     w_accept, w_last_word, w_push;

    // ---------------------------------------------------------------- buffer
    logic [ENTRY_W-1:0]       w_head_entry;
    logic [OCC_W-1:0]         w_occ;
    logic                     w_full, w_empty, w_pop;

    // ---------------------------------------------------------------- drain
    drain_state_e             drain_state_q, drain_state_d;
    logic [SW-1:0]            dev_data_q, dev_data_d;
    logic [ADDRWIDTHHOST-1:0] dev_addr_q, dev_addr_d;
    logic [NDEVICE-1:0]       done_q, done_d;
    logic [NDEVICE-1:0]       write_prev_q, w_dev_write;

    // Gated by reset_n so host_ready reads 0 while reset is held.
    assign host_ready  = reset_n && enable && !w_full;
    assign w_accept    = host_valid && host_ready;
    assign w_last_word = host_last || (int'(fill_cnt_q) == WPS - 1);
    // The first word of a stripe fixes the stripe address.
    assign w_stripe_addr = (fill_state_q == F_IDLE) ? (host_addr >> WPS_LOG2) : addr_q;

    // stripe_q is all-zero at stripe start, so an early close leaves the
    // unwritten words zero.
    always_comb begin
        w_stripe_merged = stripe_q;
        for (int k = 0; k < WPS; k++) begin
            if (int'(fill_cnt_q) == k) begin
                w_stripe_merged[k*DWIDTHHOST +: DWIDTHHOST] = host_data;
            end
        end
    end

    always_comb begin
        fill_state_d = fill_state_q;
        fill_cnt_d   = fill_cnt_q;
        stripe_d     = stripe_q;
        addr_d       = addr_q;
        w_push       = 1'b0;
        case (fill_state_q)
            F_IDLE: begin
                if (w_accept) begin
                    if (w_last_word) begin
                        w_push = 1'b1;
                    end else begin
                        fill_cnt_d   = fill_cnt_q + 1'b1;
                        stripe_d     = w_stripe_merged;
                        addr_d       = w_stripe_addr;
                        fill_state_d = F_FILL;
                    end
                end
            end
            F_FILL: begin
                if (!enable) begin
                    fill_cnt_d   = '0;
                    stripe_d     = '0;
                    addr_d       = '0;
                    fill_state_d = F_IDLE;
                end else if (w_accept) begin
                    if (w_last_word) begin
                        w_push       = 1'b1;
                        fill_cnt_d   = '0;
                        stripe_d     = '0;
                        addr_d       = '0;
                        fill_state_d = F_IDLE;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                        stripe_d   = w_stripe_merged;
                    end
                end
            end
            default: fill_state_d = F_IDLE;
        endcase
    end

    raid0_stripe_buf #(
        .DEPTH (NSTRIPE),
        .WIDTH (ENTRY_W)
    ) u_stripe_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_data ({w_stripe_addr, w_stripe_merged}),
        .pop       (w_pop),
        .head_data (w_head_entry),
        .occupancy (w_occ),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Strobes are combinational so a stripe loaded on one edge writes in the
    // following cycle; done_d is checked so the pop lands on the same edge
    // as the last strobe, giving one stripe every two cycles.
    always_comb begin
        drain_state_d = drain_state_q;
        dev_data_d    = dev_data_q;
        dev_addr_d    = dev_addr_q;
        done_d        = done_q;
        w_dev_write   = '0;
        w_pop         = 1'b0;
        case (drain_state_q)
            D_IDLE: begin
                if (w_occ != '0) begin
                    dev_data_d    = w_head_entry[SW-1:0];
                    dev_addr_d    = w_head_entry[ENTRY_W-1:SW];
                    done_d        = '0;
                    drain_state_d = D_WRITE;
                end
            end
            D_WRITE: begin
                // write_prev_q masks device_busy for the cycle after a strobe.
                w_dev_write = ~done_q & ~device_busy & ~write_prev_q;
                done_d      = done_q | w_dev_write;
                if (&done_d) begin
                    w_pop         = 1'b1;
                    dev_data_d    = '0;
                    dev_addr_d    = '0;
                    drain_state_d = D_IDLE;
                end
            end
            default: drain_state_d = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_state_q  <= F_IDLE;
            fill_cnt_q    <= '0;
            stripe_q      <= '0;
            addr_q        <= '0;
            drain_state_q <= D_IDLE;
            dev_data_q    <= '0;
            dev_addr_q    <= '0;
            done_q        <= '0;
            write_prev_q  <= '0;
        end else begin
            fill_state_q  <= fill_state_d;
            fill_cnt_q    <= fill_cnt_d;
            stripe_q      <= stripe_d;
            addr_q        <= addr_d;
            drain_state_q <= drain_state_d;
            dev_data_q    <= dev_data_d;
            dev_addr_q    <= dev_addr_d;
            done_q        <= done_d;
            write_prev_q  <= w_dev_write;
        end
    end

    assign device_data  = dev_data_q;
    assign device_addr  = dev_addr_q;
    assign device_write = w_dev_write;
    assign busy         = (fill_cnt_q != '0) || !w_empty || (drain_state_q != D_IDLE);

`ifdef RAID0_STRIPE_STAT_EN
    logic [31:0] stripes_written_q, stripes_written_d;

    always_comb begin
        stripes_written_d = stripes_written_q + {31'd0, w_pop};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stripes_written_q <= '0;
        end else begin
            stripes_written_q <= stripes_written_d;
        end
    end

    assign stripes_written = stripes_written_q;
`endif

endmodule : raid0_stripe_writer
`default_nettype wire

// File: tb/tb_raid0_stripe_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_raid0_stripe_writer
// Description : Self-checking bench for raid0_stripe_writer (default params).
//               Directed vector table, hand-written corner sequences and a
//               randomized phase scored against a stripe-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_raid0_stripe_writer;

    localparam int ND  = 8;
    localparam int DWH = 32;
    localparam int AW  = 32;
    localparam int DWD = 8;
    localparam int NS  = 2;
    localparam int WPS = (ND * DWD) / DWH;
    localparam int SW  = ND * DWD;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b1;
    logic          host_valid = 1'b0;
    logic          host_ready;
    logic [DWH-1:0] host_data = '0;
    logic [AW-1:0] host_addr = '0;
    logic          host_last = 1'b0;
    logic [SW-1:0] device_data;
    logic [AW-1:0] device_addr;
    logic [ND-1:0] device_write;
    logic [ND-1:0] device_busy = '0;
    logic          busy;
`ifdef RAID0_STRIPE_STAT_EN
    logic [31:0]   stripes_written;
`endif

    raid0_stripe_writer #(
        .NDEVICE(ND), .DWIDTHHOST(DWH), .ADDRWIDTHHOST(AW),
        .DWIDTHDEVICE(DWD), .NSTRIPE(NS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_data    (host_data),
        .host_addr    (host_addr),
        .host_last    (host_last),
        .device_data  (device_data),
        .device_addr  (device_addr),
        .device_write (device_write),
        .device_busy  (device_busy),
        .busy         (busy)
`ifdef RAID0_STRIPE_STAT_EN
        ,
        .stripes_written (stripes_written)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------ model
    // Stripe-level view: committed stripes queue up in order; a stripe leaves
    // once every device has seen exactly one strobe for it.
    typedef struct {
        logic [AW-1:0] addr;
        logic [SW-1:0] data;
    } stripe_t;

    stripe_t       exp_q[$];
    int            m_cnt  = 0;
    logic [SW-1:0] m_data = '0;
    logic [AW-1:0] m_addr = '0;
    logic [ND-1:0] m_mask = '0;
    int            m_pops = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            m_cnt  = 0;
            m_data = '0;
            m_addr = '0;
            m_mask = '0;
            m_pops = 0;
        end else begin
            chk(host_ready == (enable && (exp_q.size() < NS)), "mon_host_ready",
                64'(host_ready), 64'(enable && (exp_q.size() < NS)));
            chk(busy == ((m_cnt != 0) || (exp_q.size() != 0)), "mon_busy",
                64'(busy), 64'((m_cnt != 0) || (exp_q.size() != 0)));
            if (device_write != '0) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "mon_unexpected_strobe", 64'(device_write), 64'd0);
                end else begin
                    chk((device_write & m_mask) == '0, "mon_double_strobe",
                        64'(device_write & m_mask), 64'd0);
                    chk(device_data == exp_q[0].data, "mon_device_data",
                        device_data, exp_q[0].data);
                    chk(device_addr == exp_q[0].addr, "mon_device_addr",
                        64'(device_addr), 64'(exp_q[0].addr));
                    m_mask = m_mask | device_write;
                    if (m_mask == '1) begin
                        void'(exp_q.pop_front());
                        m_mask = '0;
                        m_pops++;
                    end
                end
            end
            if (host_valid && host_ready) begin
                if (m_cnt == 0) m_addr = host_addr / WPS;
                m_data[m_cnt*DWH +: DWH] = host_data;
                m_cnt++;
                if (host_last || m_cnt == WPS) begin
                    exp_q.push_back('{addr: m_addr, data: m_data});
                    m_cnt  = 0;
                    m_data = '0;
                end
            end else if (!enable && m_cnt != 0) begin
                m_cnt  = 0;
                m_data = '0;
            end
        end
    end

    // ------------------------------------------------------------ helpers
    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_word(input logic [DWH-1:0] d, input logic [AW-1:0] a,
                             input bit l);
        int n;
        n = 0;
        host_valid = 1'b1;
        host_data  = d;
        host_addr  = a;
        host_last  = l;
        @(negedge clk);
        while (!host_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!host_ready) chk(1'b0, "send_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(!busy && exp_q.size() == 0, name, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [DWH-1:0] d0;
        logic [AW-1:0]  a0;
        bit             l0;
        logic [DWH-1:0] d1;
        logic [AW-1:0]  a1;
        logic [SW-1:0]  exp_data;
        logic [AW-1:0]  exp_addr;
    } vec_t;

    vec_t vecs[4];
    bit   rand_run = 1'b0;

    initial begin
        vecs[0] = '{32'h11111111, 32'h40, 1'b0, 32'h22222222, 32'h41,
                    64'h2222222211111111, 32'h20};
        vecs[1] = '{32'hAABBCCDD, 32'h10, 1'b1, 32'h0, 32'h0,
                    64'h00000000AABBCCDD, 32'h08};
        vecs[2] = '{32'hDEADBEEF, 32'h7, 1'b0, 32'h01234567, 32'h8,
                    64'h01234567DEADBEEF, 32'h3};
        vecs[3] = '{32'h0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'h0,
                    64'hFFFFFFFF00000000, 32'h7FFFFFFF};

        // Reset state, with enable high so host_ready gating is exercised.
        #2;
        chk(host_ready == 1'b0, "reset_host_ready", 64'(host_ready), 64'd0);
        chk(device_write == '0, "reset_device_write", 64'(device_write), 64'd0);
        chk(device_data == '0, "reset_device_data", device_data, 64'd0);
        chk(busy == 1'b0, "reset_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Directed vectors: 2-cycle latency, all lanes strobed once.
        for (int i = 0; i < 4; i++) begin
            send_word(vecs[i].d0, vecs[i].a0, vecs[i].l0);
            if (!vecs[i].l0) send_word(vecs[i].d1, vecs[i].a1, 1'b0);
            @(negedge clk);
            chk(device_write == '0, "vec_early_write", 64'(device_write), 64'd0);
            @(negedge clk);
            chk(device_write == 8'hFF, "vec_write", 64'(device_write), 64'hFF);
            chk(device_data == vecs[i].exp_data, "vec_data", device_data, vecs[i].exp_data);
            chk(device_addr == vecs[i].exp_addr, "vec_addr", 64'(device_addr),
                64'(vecs[i].exp_addr));
            @(negedge clk);
            chk(device_write == '0, "vec_single_cycle", 64'(device_write), 64'd0);
            chk(device_data == '0, "vec_data_idle", device_data, 64'd0);
            @(posedge clk);
            #1;
        end

        // One busy lane stalls only itself.
        device_busy = 8'h04;
        send_word(32'h33333333, 32'h50, 1'b0);
        send_word(32'h44444444, 32'h51, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk(device_write == 8'hFB, "busy_lane_first", 64'(device_write), 64'hFB);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk(device_write == '0, "busy_lane_hold", 64'(device_write), 64'd0);
        end
        @(posedge clk);
        #1;
        device_busy = 8'h00;
        @(negedge clk);
        chk(device_write == 8'h04, "busy_lane_late", 64'(device_write), 64'h04);
        chk(device_data == 64'h4444444433333333, "busy_lane_data", device_data,
            64'h4444444433333333);
        @(negedge clk);
        chk(busy == 1'b0, "busy_lane_pop", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Full buffer back-pressure.
        device_busy = 8'hFF;
        send_word(32'hA0, 32'h100, 1'b0);
        send_word(32'hA1, 32'h101, 1'b0);
        send_word(32'hB0, 32'h102, 1'b0);
        send_word(32'hB1, 32'h103, 1'b0);
        host_valid = 1'b1;
        host_data  = 32'hC0;
        host_addr  = 32'h104;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(host_ready == 1'b0, "full_ready_low", 64'(host_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        device_busy = 8'h00;
        @(negedge clk);
        chk(device_write == 8'hFF, "full_pop_strobe", 64'(device_write), 64'hFF);
        chk(host_ready == 1'b0, "full_ready_at_pop", 64'(host_ready), 64'd0);
        @(negedge clk);
        chk(host_ready == 1'b1, "full_ready_after_pop", 64'(host_ready), 64'd1);
        @(posedge clk);
        #1;
        send_word(32'hC1, 32'h105, 1'b0);
        wait_idle("full_drain_idle");

        // Enable dropped mid-stripe discards the partial stripe.
        send_word(32'h55555555, 32'h60, 1'b0);
        enable = 1'b0;
        @(negedge clk);
        chk(busy == 1'b1, "enable_partial_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk(busy == 1'b0, "enable_discard_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        enable = 1'b1;
        repeat (4) @(negedge clk);
        chk(device_write == '0 && !busy, "enable_no_strobe", 64'(device_write), 64'd0);
        @(posedge clk);
        #1;

        // Reset asserted mid-drain clears outputs immediately.
        device_busy = 8'h01;
        send_word(32'h66666666, 32'h70, 1'b0);
        send_word(32'h77777777, 32'h71, 1'b0);
        repeat (3) @(negedge clk);
        chk(device_data == 64'h7777777766666666, "rst_pre_data", device_data,
            64'h7777777766666666);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk(host_ready == 1'b0, "rst_mid_ready", 64'(host_ready), 64'd0);
        chk(device_write == '0, "rst_mid_write", 64'(device_write), 64'd0);
        chk(device_data == '0, "rst_mid_data", device_data, 64'd0);
        chk(device_addr == '0, "rst_mid_addr", 64'(device_addr), 64'd0);
        chk(busy == 1'b0, "rst_mid_busy", 64'(busy), 64'd0);
`ifdef RAID0_STRIPE_STAT_EN
        chk(stripes_written == 32'd0, "rst_stat", 64'(stripes_written), 64'd0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        device_busy = 8'h00;
        repeat (4) @(negedge clk);
        chk(busy == 1'b0 && device_write == '0, "rst_no_stale", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Randomized traffic with random per-lane busy.
        rand_run = 1'b1;
        fork
            begin
                while (1) begin
                    @(posedge clk);
                    #1;
                    if (!rand_run) begin
                        device_busy = 8'h00;
                        break;
                    end
                    device_busy = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
                end
            end
        join_none
        for (int s = 0; s < 60; s++) begin
            int nw;
            nw = $urandom_range(1, WPS);
            if ($urandom_range(0, 7) == 0) begin
                send_word($urandom, $urandom, 1'b0);
                enable = 1'b0;
                @(posedge clk);
                #1;
                enable = 1'b1;
            end
            for (int w = 0; w < nw; w++) begin
                send_word($urandom, $urandom,
                          (w == nw - 1) && (nw < WPS || $urandom_range(0, 1) == 1));
            end
        end
        rand_run = 1'b0;
        wait_idle("rand_drain_idle");

`ifdef RAID0_STRIPE_STAT_EN
        chk(stripes_written == 32'(m_pops), "stat_count", 64'(stripes_written),
            64'(m_pops));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=0", $time);
        $fatal(1);
    end

endmodule : tb_raid0_stripe_writer
`default_nettype wire
